// File: rtl/axis_cpu_dout_fifo_if.sv
// AXI-Stream link bundle used on both sides of axis_cpu_dout_fifo.
// The master drives data/last/valid and the slave drives ready.
interface axis_cpu_dout_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TLAST;
  logic                  TVALID;
  logic                  TREADY;

  modport master (output TDATA, output TLAST, output TVALID, input TREADY);
  modport slave  (input TDATA, input TLAST, input TVALID, output TREADY);
endinterface

// File: rtl/axis_cpu_dout_fifo.sv
// axis_cpu_dout_fifo: transmit-side first-word-fall-through buffer between
// the CPU writeback stage (cpu port, slave side) and the external
// AXI-Stream master port (dout port). Holds 2**DEPTH_LOG2 flits of
// {last, data}. Pointers carry one extra MSB so that full and empty are
// distinguished without a separate flag.
// Optional build macro AXIS_CPU_DOUT_PKT_CNT_EN adds pkt_count (packets
// completed on dout) and pkt_open (a packet is partially sent).
module axis_cpu_dout_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  axis_cpu_dout_fifo_if.slave       cpu,
  axis_cpu_dout_fifo_if.master      dout,
`ifdef AXIS_CPU_DOUT_PKT_CNT_EN
  output logic [15:0]               pkt_count,
  output logic [0:0]                pkt_open,
`endif
  output logic [DEPTH_LOG2:0]       count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH:0]   mem_r [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_r;
  logic [DEPTH_LOG2:0]   rd_ptr_r;
  logic                  empty_s;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;
  logic [DATA_WIDTH:0]   head_s;

  // Status flags and handshakes derived purely from registered pointers;
  // ready never looks at dout.TREADY, so a full buffer refuses pushes even
  // while it is being popped.
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]) &&
              (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]);
    push_s  = cpu.TVALID && !full_s && !rst;
    pop_s   = !empty_s && !rst && dout.TREADY;
    head_s  = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
  end

  assign cpu.TREADY  = !full_s && !rst;
  assign dout.TVALID = !empty_s && !rst;
  assign dout.TDATA  = head_s[DATA_WIDTH-1:0];
  assign dout.TLAST  = head_s[DATA_WIDTH];
  assign count       = wr_ptr_r - rd_ptr_r;

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= {cpu.TLAST, cpu.TDATA};
    end
  end

  // Pointer update; reset discards every buffered flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
      end
    end
  end

`ifdef AXIS_CPU_DOUT_PKT_CNT_EN
  // Packet bookkeeping on the output side: count TLAST pops, track open packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= 16'd0;
      pkt_open  <= 1'b0;
    end else if (pop_s) begin
      if (head_s[DATA_WIDTH]) begin
        pkt_count <= pkt_count + 16'd1;
        pkt_open  <= 1'b0;
      end else begin
        pkt_open  <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_cpu_dout_fifo.sv
// Self-checking bench for axis_cpu_dout_fifo (DEPTH_LOG2=2). A queue holds
// the expected buffer contents; directed scenarios plus a randomized run
// compare the DUT against it. Build with AXIS_CPU_DOUT_PKT_CNT_EN to
// exercise the packet counter as well.
module tb_axis_cpu_dout_fifo;
  localparam int DW = 32;
  localparam int DL = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DL:0] count;
  axis_cpu_dout_fifo_if #(.DATA_WIDTH(DW)) cpu_if ();
  axis_cpu_dout_fifo_if #(.DATA_WIDTH(DW)) dout_if ();
`ifdef AXIS_CPU_DOUT_PKT_CNT_EN
  logic [15:0] pkt_count;
  logic [0:0]  pkt_open;
  int          m_pkts = 0;
  logic        m_open = 1'b0;
`endif

  axis_cpu_dout_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .clk   (clk),
    .rst   (rst),
    .cpu   (cpu_if),
    .dout  (dout_if),
`ifdef AXIS_CPU_DOUT_PKT_CNT_EN
    .pkt_count (pkt_count),
    .pkt_open  (pkt_open),
`endif
    .count (count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DW:0] q[$];     // expected contents, front = oldest
  logic [DW:0] seen[$];  // flits observed leaving the DUT

  // One clock edge: record the DUT pop, then advance the reference queue.
  task automatic step();
    bit push, pop;
    logic [DW:0] flit;
    push = !rst && cpu_if.TVALID && (q.size() < DEPTH);
    pop  = !rst && dout_if.TREADY && (q.size() > 0);
    flit = {cpu_if.TLAST, cpu_if.TDATA};
    if (dout_if.TVALID && dout_if.TREADY) seen.push_back({dout_if.TLAST, dout_if.TDATA});
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
`ifdef AXIS_CPU_DOUT_PKT_CNT_EN
      m_pkts = 0;
      m_open = 1'b0;
`endif
    end else begin
      if (pop) begin
`ifdef AXIS_CPU_DOUT_PKT_CNT_EN
        if (q[0][DW]) begin
          m_pkts = (m_pkts + 1) % 65536;
          m_open = 1'b0;
        end else begin
          m_open = 1'b1;
        end
`endif
        void'(q.pop_front());
      end
      if (push) q.push_back(flit);
    end
  endtask

  task automatic drain();
    cpu_if.TVALID = 1'b0;
    dout_if.TREADY = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) step();
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL drain_count: got %0d want 0", count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_if.TVALID = 1'b0; cpu_if.TDATA = '0; cpu_if.TLAST = 1'b0;
    dout_if.TREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dout_if.TVALID !== 1'b0 || cpu_if.TREADY !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: tvalid=%b tready=%b want 0 0", dout_if.TVALID, cpu_if.TREADY);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cpu_if.TREADY !== 1'b1 || count !== 3'd0 || dout_if.TVALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: tready=%b count=%0d tvalid=%b want 1 0 0",
               cpu_if.TREADY, count, dout_if.TVALID);
    end
  endtask

  task automatic test_single_latency();
    dout_if.TREADY = 1'b1;
    cpu_if.TVALID = 1'b1; cpu_if.TDATA = 32'hDEADBEEF; cpu_if.TLAST = 1'b1;
    step();
    cpu_if.TVALID = 1'b0;
    checks++;
    if (dout_if.TVALID !== 1'b1 || dout_if.TDATA !== 32'hDEADBEEF || dout_if.TLAST !== 1'b1) begin
      errors++;
      $display("FAIL single_out: tvalid=%b data=%h last=%b want 1 deadbeef 1",
               dout_if.TVALID, dout_if.TDATA, dout_if.TLAST);
    end
    step();
    checks++;
    if (count !== 3'd0 || dout_if.TVALID !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: count=%0d tvalid=%b want 0 0", count, dout_if.TVALID);
    end
  endtask

  task automatic test_fill_backpressure();
    seen.delete();
    dout_if.TREADY = 1'b0;
    cpu_if.TLAST = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cpu_if.TVALID = 1'b1; cpu_if.TDATA = i;
      step();
    end
    checks++;
    if (cpu_if.TREADY !== 1'b0 || count !== 3'd4) begin
      errors++;
      $display("FAIL fill_full: tready=%b count=%0d want 0 4", cpu_if.TREADY, count);
    end
    cpu_if.TDATA = 32'h5;
    step(); step();
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL fill_hold: count=%0d want 4", count);
    end
    dout_if.TREADY = 1'b1;
    step();
    checks++;
    if (count !== 3'd3 || cpu_if.TREADY !== 1'b1) begin
      errors++;
      $display("FAIL fill_release: count=%0d tready=%b want 3 1", count, cpu_if.TREADY);
    end
    step();
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL fill_accept5: count=%0d want 3", count);
    end
    drain();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (seen.size() <= i || seen[i] !== {1'b0, 32'(i + 1)}) begin
        errors++;
        $display("FAIL fill_order[%0d]: got %h want %h", i,
                 (seen.size() > i) ? seen[i] : 33'h0, {1'b0, 32'(i + 1)});
      end
    end
  endtask

  task automatic test_full_pop();
    seen.delete();
    dout_if.TREADY = 1'b0;
    cpu_if.TLAST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_if.TVALID = 1'b1; cpu_if.TDATA = 32'h40 + i;
      step();
    end
    cpu_if.TDATA = 32'h44;
    dout_if.TREADY = 1'b1;
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL fullpop_pre: count=%0d want 4", count);
    end
    step();
    dout_if.TREADY = 1'b0;
    checks++;
    if (count !== 3'd3 || cpu_if.TREADY !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_refuse: count=%0d tready=%b want 3 1", count, cpu_if.TREADY);
    end
    step();
    cpu_if.TVALID = 1'b0;
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL fullpop_accept: count=%0d want 4", count);
    end
    drain();
    checks++;
    if (seen.size() != 5 || seen[4] !== {1'b0, 32'h44}) begin
      errors++;
      $display("FAIL fullpop_last: size=%0d want 5 ending 44", seen.size());
    end
  endtask

  task automatic test_wrap();
    seen.delete();
    dout_if.TREADY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cpu_if.TVALID = 1'b1; cpu_if.TDATA = 32'h10 + i; cpu_if.TLAST = (i == 19);
      step();
      checks++;
      if (count > 3'd1) begin
        errors++;
        $display("FAIL wrap_count: cycle %0d count=%0d want <=1", i, count);
      end
    end
    drain();
    checks++;
    if (seen.size() != 20) begin
      errors++;
      $display("FAIL wrap_len: got %0d want 20", seen.size());
    end
    for (int i = 0; i < 20 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== {(i == 19) ? 1'b1 : 1'b0, 32'h10 + 32'(i)}) begin
        errors++;
        $display("FAIL wrap_seq[%0d]: got %h want %h", i, seen[i],
                 {(i == 19) ? 1'b1 : 1'b0, 32'h10 + 32'(i)});
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      cpu_if.TVALID = $urandom_range(0, 1);
      cpu_if.TDATA = $urandom;
      cpu_if.TLAST = $urandom_range(0, 1);
      dout_if.TREADY = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (cpu_if.TREADY !== (!rst && q.size() < DEPTH) ||
          dout_if.TVALID !== (!rst && q.size() > 0) || count !== 3'(q.size())) begin
        errors++;
        $display("FAIL rand_status[%0d]: tready=%b tvalid=%b count=%0d model_size=%0d rst=%b",
                 c, cpu_if.TREADY, dout_if.TVALID, count, q.size(), rst);
      end
      if (!rst && q.size() > 0) begin
        checks++;
        if ({dout_if.TLAST, dout_if.TDATA} !== q[0]) begin
          errors++;
          $display("FAIL rand_head[%0d]: got %h want %h", c, {dout_if.TLAST, dout_if.TDATA}, q[0]);
        end
      end
`ifdef AXIS_CPU_DOUT_PKT_CNT_EN
      checks++;
      if (pkt_count !== 16'(m_pkts) || pkt_open !== m_open) begin
        errors++;
        $display("FAIL rand_pkt[%0d]: count=%0d open=%b want %0d %b", c, pkt_count, pkt_open, m_pkts, m_open);
      end
`endif
      step();
    end
    rst = 1'b0;
    drain();
  endtask

  task automatic test_mid_reset();
`ifdef AXIS_CPU_DOUT_PKT_CNT_EN
    int lens[3] = '{2, 1, 3};
    rst = 1'b1; step(); rst = 1'b0;
    dout_if.TREADY = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < lens[p]; j++) begin
        cpu_if.TVALID = 1'b1; cpu_if.TDATA = 32'h100 * (p + 1) + j; cpu_if.TLAST = (j == lens[p] - 1);
        step();
      end
    end
    drain();
    checks++;
    if (pkt_count !== 16'd3 || pkt_open !== 1'b0) begin
      errors++;
      $display("FAIL pkt_three: count=%0d open=%b want 3 0", pkt_count, pkt_open);
    end
`endif
    seen.delete();
    dout_if.TREADY = 1'b0;
    cpu_if.TLAST = 1'b0;
    for (int j = 0; j < 2; j++) begin
      cpu_if.TVALID = 1'b1; cpu_if.TDATA = 32'hBAD0 + j;
      step();
    end
    cpu_if.TVALID = 1'b0;
`ifdef AXIS_CPU_DOUT_PKT_CNT_EN
    dout_if.TREADY = 1'b1;
    step();
    dout_if.TREADY = 1'b0;
    checks++;
    if (pkt_open !== 1'b1) begin
      errors++;
      $display("FAIL pkt_open_set: got %b want 1", pkt_open);
    end
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || dout_if.TVALID !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: count=%0d tvalid=%b want 0 0", count, dout_if.TVALID);
    end
`ifdef AXIS_CPU_DOUT_PKT_CNT_EN
    checks++;
    if (pkt_count !== 16'd0 || pkt_open !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pkt: count=%0d open=%b want 0 0", pkt_count, pkt_open);
    end
`endif
    dout_if.TREADY = 1'b1;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (seen.size() != 0 || dout_if.TVALID !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stale: popped=%0d tvalid=%b want 0 0", seen.size(), dout_if.TVALID);
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_fill_backpressure();
    test_full_pop();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
